// File: rtl/led_speed_ctrl_module.sv
// Key debounce, speed/pause control and step-tick generation for the running-LED shifter.
// Optional direction key is enabled by defining LED_DIR_KEY_EN; otherwise Dir is tied 0.
module led_speed_ctrl_module #(
  parameter logic [22:0] DEBOUNCE_CYC = 23'd1_000_000,
  parameter logic [22:0] BASE_CYC     = 23'd625_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       KEY_Up_n,
  input  logic       KEY_Dn_n,
  input  logic       KEY_Pause_n,
  input  logic       KEY_Dir_n,
  output logic       Step_Tick,
  output logic [2:0] Speed_Level,
  output logic       Paused,
  output logic       Dir
);

`ifdef LED_DIR_KEY_EN
  localparam int NK = 4;
  logic [NK-1:0] key_raw;
  assign key_raw = {KEY_Dir_n, KEY_Pause_n, KEY_Dn_n, KEY_Up_n};
`else
  localparam int NK = 3;
  logic [NK-1:0] key_raw;
  logic          unused_dir_key;
  assign key_raw        = {KEY_Pause_n, KEY_Dn_n, KEY_Up_n};
  assign unused_dir_key = KEY_Dir_n;
`endif

  logic [NK-1:0] sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
  logic [22:0]   dcnt_q [NK];
  logic [22:0]   dcnt_d [NK];

  // A key level is accepted only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      stable_d[k] = stable_q[k];
      dcnt_d[k]   = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (dcnt_q[k] == DEBOUNCE_CYC - 23'd1) stable_d[k] = sync2_q[k];
        else                                    dcnt_d[k]   = dcnt_q[k] + 23'd1;
      end
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      for (int k = 0; k < NK; k++) dcnt_q[k] <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int k = 0; k < NK; k++) dcnt_q[k] <= dcnt_d[k];
    end
  end

  logic       up_ev, dn_ev, pause_ev;
  logic [2:0] level_q, level_d;
  logic       paused_q, paused_d;

  assign up_ev    = press_q[0];
  assign dn_ev    = press_q[1];
  assign pause_ev = press_q[2];

  always_comb begin
    level_d = level_q;
    if (up_ev && !dn_ev && level_q != 3'd7)      level_d = level_q + 3'd1;
    else if (dn_ev && !up_ev && level_q != 3'd0) level_d = level_q - 3'd1;
    paused_d = paused_q ^ pause_ev;
  end

  logic [22:0] period;
  logic [22:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  assign period = BASE_CYC * {19'd0, 4'd8 - {1'b0, level_q}};

  // A level change restarts the period so the new rate takes effect immediately.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (level_d != level_q) begin
      cnt_d = '0;
    end else if (!paused_q) begin
      if (cnt_q == period - 23'd1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 23'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      level_q  <= '0;
      paused_q <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      level_q  <= level_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

`ifdef LED_DIR_KEY_EN
  logic dir_q;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) dir_q <= 1'b0;
    else       dir_q <= dir_q ^ press_q[3];
  end
  assign Dir = dir_q;
`else
  assign Dir = 1'b0;
`endif

  assign Step_Tick   = tick_q;
  assign Speed_Level = level_q;
  assign Paused      = paused_q;

endmodule

// File: tb/tb_led_speed_ctrl_module.sv
// Bench for led_speed_ctrl_module: key table, corner sequences, randomized key traffic.
// Tick spacing is checked continuously against the rule "P un-paused cycles between ticks".
module tb_led_speed_ctrl_module;
  localparam int DEB  = 8;
  localparam int BASE = 4;
`ifdef LED_DIR_KEY_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       up_n = 1'b1, dn_n = 1'b1, pause_n = 1'b1, dir_n = 1'b1;
  logic       Step_Tick;
  logic [2:0] Speed_Level;
  logic       Paused, Dir;

  int vectors = 0;
  int miscompares = 0;
  int exp_level = 0;
  int exp_paused = 0;
  int exp_dir = 0;

  always #5 CLK = ~CLK;

  led_speed_ctrl_module #(.DEBOUNCE_CYC(23'd8), .BASE_CYC(23'd4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .KEY_Up_n(up_n), .KEY_Dn_n(dn_n), .KEY_Pause_n(pause_n), .KEY_Dir_n(dir_n),
    .Step_Tick(Step_Tick), .Speed_Level(Speed_Level), .Paused(Paused), .Dir(Dir)
  );

  typedef struct {
    logic [3:0] mask;   // {dir, pause, dn, up}, 1 = pressed
    int         hold;
    int         exp_level;
    int         exp_paused;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] m);
    {dir_n, pause_n, dn_n, up_n} = ~m;
  endtask

  // Reference: a key held at least DEB cycles is one press; simultaneous up/dn cancel.
  task automatic model_press(input logic [3:0] m, input int hold);
    if (hold >= DEB) begin
      if (m[0] && !m[1] && exp_level < 7) exp_level = exp_level + 1;
      if (m[1] && !m[0] && exp_level > 0) exp_level = exp_level - 1;
      if (m[2]) exp_paused = 1 - exp_paused;
      if (m[3] && DIR_EN) exp_dir = 1 - exp_dir;
    end
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    drive(m);
    cyc(hold);
    drive(4'b0000);
    cyc(gap);
    model_press(m, hold);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, int'(Speed_Level), exp_level);
    chk({tag, "_paused"}, int'(Paused), exp_paused);
    chk({tag, "_dir"}, int'(Dir), exp_dir);
  endtask

  task automatic monitor();
    int active = 0;
    int plev = 0;
    bit ptick = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        active = 0;
        plev   = 0;
        ptick  = 1'b0;
      end else begin
        if (ptick) chk("no_double_tick", int'(Step_Tick), 0);
        if (int'(Speed_Level) != plev) begin
          chk("no_tick_on_level_change", int'(Step_Tick), 0);
          active = 0;
        end else if (Step_Tick) begin
          chk("tick_period", active, BASE * (8 - int'(Speed_Level)));
          active = 0;
        end
        if (!Paused) active++;
        ptick = Step_Tick;
        plev  = int'(Speed_Level);
      end
    end
  endtask

  vec_t tbl [21];
  int   ticks;

  initial begin
    tbl[0] = '{4'b0001, 20, 1, 0};
    for (int i = 1; i < 7; i++) tbl[i] = '{4'b0001, 20, i + 1, 0};
    tbl[7]  = '{4'b0001, 20, 7, 0};   // saturate high
    tbl[8]  = '{4'b0010, 20, 6, 0};
    tbl[9]  = '{4'b0011, 20, 6, 0};   // up+dn together cancel
    tbl[10] = '{4'b0100, 20, 6, 1};
    tbl[11] = '{4'b0001,  5, 6, 1};   // too short to accept
    tbl[12] = '{4'b0100, 20, 6, 0};
    for (int i = 13; i < 19; i++) tbl[i] = '{4'b0010, 20, 18 - i, 0};
    tbl[19] = '{4'b0010, 20, 0, 0};   // saturate low
    tbl[20] = '{4'b0011,  4, 0, 0};

    fork
      monitor();
    join_none

    cyc(4);
    chk("reset_tick", int'(Step_Tick), 0);
    check_state("reset");
    RSTn = 1'b1;
    cyc(100);
    check_state("idle");

    foreach (tbl[i]) begin
      press(tbl[i].mask, tbl[i].hold, 16);
      exp_level  = tbl[i].exp_level;
      exp_paused = tbl[i].exp_paused;
      chk($sformatf("tbl%0d_level", i), int'(Speed_Level), tbl[i].exp_level);
      chk($sformatf("tbl%0d_paused", i), int'(Paused), tbl[i].exp_paused);
    end

    for (int i = 0; i < 10; i++) begin
      up_n = ~up_n;
      cyc(3);
    end
    up_n = 1'b1;
    cyc(16);
    check_state("bounce");

    press(4'b0100, 20, 4);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (Step_Tick) ticks++;
    end
    chk("paused_no_ticks", ticks, 0);
    check_state("paused");
    press(4'b0100, 20, 40);
    check_state("resumed");

    for (int i = 0; i < 5; i++) press(4'b0001, 20, 16);
    press(4'b0100, 20, 16);
    check_state("lvl5_paused");
    drive(4'b0001);
    cyc(5);
    RSTn = 1'b0;
    cyc(1);
    exp_level = 0; exp_paused = 0; exp_dir = 0;
    chk("midreset_tick", int'(Step_Tick), 0);
    check_state("midreset");
    cyc(3);
    RSTn = 1'b1;
    cyc(20);
    drive(4'b0000);
    cyc(16);
    model_press(4'b0001, 20);
    check_state("held_through_reset");
    press(4'b1000, 20, 16);
    check_state("dir_press");

    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      int         hold;
      m    = 4'($urandom_range(1, 15));
      hold = ($urandom_range(0, 1) == 1) ? $urandom_range(12, 25) : $urandom_range(1, 5);
      press(m, hold, $urandom_range(16, 22));
      check_state($sformatf("rnd%0d", i));
    end
    cyc(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
